// File: rtl/tick_scheduler.sv
// Multi-channel tick generator: each channel divides clk_in by a programmable
// value and emits a registered one-cycle enable pulse while the scheduler runs.
// Divide values may only be changed while idle or paused.
module tick_scheduler #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              cfg_valid,
  input  logic [1:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StPaused = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_d [NUM_CH];
  logic [CNT_W-1:0]   div_q [NUM_CH];
  logic [CNT_W-1:0]   div_d [NUM_CH];
  logic [NUM_CH-1:0]  tick_q, tick_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_accept;
  logic               cfg_ok;
  logic               counting;

  // Next-state decode; stop always wins, the unused encoding falls back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StRun;
      end
      StRun: begin
        if (stop)       state_d = StIdle;
        else if (pause) state_d = StPaused;
      end
      StPaused: begin
        if (stop)       state_d = StIdle;
        else if (start) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cfg_ready  = (state_q == StIdle) || (state_q == StPaused);
  assign cfg_accept = cfg_valid && cfg_ready;
  assign cfg_ok     = (cfg_div != '0) && (32'(cfg_ch) < NUM_CH);
  // Only edges that stay in RUN advance the counters, so the pause edge keeps
  // the count and a resume continues without losing or adding a pulse.
  assign counting   = (state_q == StRun) && (state_d == StRun);

  // Per-channel counter/divider next state and tick generation.
  always_comb begin
    tick_d    = '0;
    cfg_err_d = cfg_accept && !cfg_ok;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      if (cfg_accept && cfg_ok && (cfg_ch == 2'(i))) begin
        div_d[i] = cfg_div;
        cnt_d[i] = '0;
      end
      if (counting) begin
        if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (state_d == StIdle) cnt_d[i] = '0;
    end
  end

  // State, counters, dividers and registered outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(DEFAULT_DIV);
      end
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
    end
  end

  assign tick    = tick_q;
  assign cfg_err = cfg_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: stimulus pushes expected tick/cfg_err
// events (cycle, value); a negedge monitor pops one per observed pulse.
module tb_tick_scheduler;

  localparam int NCH = 3;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start, pause, stop, cfg_valid;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_ready, cfg_err;
  logic [2:0]  tick;
  logic [1:0]  state;

  typedef struct {
    int         cyc;
    logic [2:0] tck;
    logic       err;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  exp_div[NCH];

  tick_scheduler #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(2)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .tick     (tick),
    .state    (state)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every pulse on tick or cfg_err must match the head of the queue.
  always @(negedge clk_in) begin : monitor
    ev_t e;
    if (reset && ((tick != 3'b000) || cfg_err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d got tick=%b err=%b, required no pulse",
                 cyc, tick, cfg_err);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.tck != tick || e.err != cfg_err) begin
          n_fail++;
          $display("FAIL event got cyc=%0d tick=%b err=%b, required cyc=%0d tick=%b err=%b",
                   cyc, tick, cfg_err, e.cyc, e.tck, e.err);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_ev(input int c, input logic [2:0] t, input logic err);
    ev_t e;
    e.cyc = c;
    e.tck = t;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Expected pulses for a RUN window entered at edge e from cleared counters;
  // the stop edge is e+len, so counting edges are e+1 .. e+len-1.
  task automatic push_run(input int e, input int len);
    logic [2:0] v;
    for (int k = 1; k < len; k++) begin
      v = '0;
      for (int c = 0; c < NCH; c++) v[c] = ((k % exp_div[c]) == 0);
      if (v != 3'b000) push_ev(e + k, v, 1'b0);
    end
  endtask

  task automatic do_cfg(input logic [1:0] ch, input logic [15:0] dv);
    check("cfg_ready_idle", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
    if (dv == 16'd0 || int'(ch) >= NCH) push_ev(cyc + 1, 3'b000, 1'b1);
    else exp_div[ch] = int'(dv);
    step();
    cfg_valid = 1'b0;
  endtask

  // Start, run for len cycles, then stop (optionally with pause as well).
  // probe drives a config request while running, which must be ignored.
  task automatic run_window(input int len, input logic with_pause, input logic probe);
    push_run(cyc + 1, len);
    start = 1'b1;
    step();
    start = 1'b0;
    check("state_run", int'(state), 1);
    check("cfg_ready_run", int'(cfg_ready), 0);
    if (probe) begin
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_div   = 16'd1;
      step();
      cfg_valid = 1'b0;
      step_n(len - 2);
    end else begin
      step_n(len - 1);
    end
    stop  = 1'b1;
    pause = with_pause;
    step();
    stop  = 1'b0;
    pause = 1'b0;
    check("state_idle_after_stop", int'(state), 0);
  endtask

  initial begin : stim
    int r;
    reset = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = 2'd0;
    cfg_div = 16'd0;
    for (int c = 0; c < NCH; c++) exp_div[c] = 2;
    repeat (3) @(negedge clk_in);
    check("reset_state", int'(state), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_cfg_err", int'(cfg_err), 0);
    check("reset_cfg_ready", int'(cfg_ready), 1);
    reset = 1'b1;
    step();

    // Defaults: all channels pulse together every 2nd cycle.
    run_window(9, 1'b0, 1'b0);

    // Mixed dividers.
    do_cfg(2'd1, 16'd5);
    do_cfg(2'd2, 16'd1);
    run_window(11, 1'b0, 1'b0);

    // Pause after two counts, hold, resume: pulse two cycles after resume.
    do_cfg(2'd0, 16'd4);
    do_cfg(2'd1, 16'd100);
    do_cfg(2'd2, 16'd100);
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(2);
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("state_paused", int'(state), 2);
    step_n(10);
    check("tick_paused", int'(tick), 0);
    check("cfg_ready_paused", int'(cfg_ready), 1);
    r = cyc + 1;
    push_ev(r + 2, 3'b001, 1'b0);
    push_ev(r + 6, 3'b001, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("state_resumed", int'(state), 1);
    step_n(6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("state_idle_after_resume", int'(state), 0);

    // Rejected configs, then a request while running that must be ignored.
    do_cfg(2'd0, 16'd0);
    do_cfg(2'd3, 16'd9);
    step();
    run_window(9, 1'b0, 1'b1);

    // start+stop while paused goes idle and clears counters.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("state_paused2", int'(state), 2);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("state_start_stop", int'(state), 0);
    // pause+stop in RUN must also go idle; first pulse proves counters cleared.
    run_window(5, 1'b1, 1'b0);

    // Reset between edges while ch2 is pulsing.
    do_cfg(2'd2, 16'd1);
    push_run(cyc + 1, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(5);
    @(negedge clk_in);
    #2;
    reset = 1'b0;
    #1;
    check("midrun_reset_state", int'(state), 0);
    check("midrun_reset_tick", int'(tick), 0);
    check("midrun_reset_cfg_ready", int'(cfg_ready), 1);
    for (int c = 0; c < NCH; c++) exp_div[c] = 2;
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
    // Dividers are back to the default of 2.
    run_window(5, 1'b0, 1'b0);
    step_n(3);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of independent tick channels (1..4).
REQ-002 SHALL have parameter CNT_W, default 16, width of divide values and channel counters.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2, divide value loaded into every channel at reset (1..2^CNT_W-1).
REQ-004 SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  level-sampled command: IDLE/PAUSED to RUN.
REQ-007 SHALL have port pause  input  1  level-sampled command: RUN to PAUSED.
REQ-008 SHALL have port stop  input  1  level-sampled command: any state to IDLE.
REQ-009 SHALL have port cfg_valid  input  1  configuration request valid.
REQ-010 SHALL have port cfg_ch  input  2  target channel index.
REQ-011 SHALL have port cfg_div  input  CNT_W  requested divide value.
REQ-012 SHALL have port cfg_ready  output  1  configuration may be accepted this cycle.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse: accepted request rejected.
REQ-014 SHALL have port tick  output  NUM_CH  per-channel one-cycle enable pulses.
REQ-015 SHALL have port state  output  2  FSM state: IDLE=00, RUN=01, PAUSED=10; 11 unused.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSED; encoding 11 SHALL never be reached and, if forced, SHALL go to IDLE on the next edge.
REQ-017 SHALL transition IDLE->RUN when start=1 and stop=0; otherwise remain in IDLE.
REQ-018 SHALL transition RUN->IDLE when stop=1, else RUN->PAUSED when pause=1; stop has priority over pause.
REQ-019 SHALL transition PAUSED->IDLE when stop=1, else PAUSED->RUN when start=1; stop has priority over start.
REQ-020 SHALL clear all channel counters to 0 on the edge that enters IDLE and hold them at 0 while in IDLE.
REQ-021 SHALL, in RUN, per channel: if counter == div-1 then counter<=0 and tick[i]=1 for the following cycle, else counter<=counter+1 and tick[i]=0.
REQ-022 SHALL register tick, so a channel with div=N pulses once every N cycles, first pulse N cycles after the RUN-entry edge.
REQ-023 SHALL produce tick[i]=1 on every RUN cycle when div=1.
REQ-024 SHALL, in PAUSED, hold all counters at their values and drive tick=0; resume continues the count with no lost or extra pulse.
REQ-025 SHALL drive tick=0 in IDLE and PAUSED and on the cycle after leaving RUN.
REQ-026 SHALL drive cfg_ready=1 exactly when state is IDLE or PAUSED.
REQ-027 SHALL accept a request on an edge where cfg_valid=1 and cfg_ready=1; cfg_valid with cfg_ready=0 SHALL be ignored with no side effect.
REQ-028 SHALL, on accept with cfg_div != 0 and cfg_ch < NUM_CH, load div[cfg_ch]<=cfg_div and clear counter[cfg_ch] to 0.
REQ-029 SHALL, on accept with cfg_div == 0 or cfg_ch >= NUM_CH, leave all div and counters unchanged and pulse cfg_err=1 for the following cycle.
REQ-030 SHALL apply a configuration accepted on the same edge as a PAUSED->RUN transition; the new div governs the first RUN cycle.
REQ-031 SHALL treat counter/div comparison as unsigned CNT_W-bit; counter never exceeds div-1.

Reset
REQ-032 SHALL, while reset=0, asynchronously force state=IDLE, all counters=0, all div=DEFAULT_DIV, tick=0, cfg_err=0; cfg_ready SHALL read 1.
REQ-033 SHALL, on reset assertion mid-RUN, abort all counting immediately; no tick pulse after reset asserts.
REQ-034 SHALL resume normal operation on the first clk_in rising edge after reset deasserts.

Verification
REQ-035 SHALL cover: reset, start=1 one cycle, defaults (DIV=2) -> tick=111 every 2nd cycle, first pulse 2 cycles after RUN entry.
REQ-036 SHALL cover: in IDLE cfg ch1 div=5, ch2 div=1, start -> tick[1] period 5, tick[2] high every RUN cycle, tick[0] period 2.
REQ-037 SHALL cover: RUN with ch0 div=4, pause after counter=2, hold 10 cycles, start -> next tick[0] exactly 2 cycles after resume (2 counted before + 2 after = 4 total).
REQ-038 SHALL cover: cfg_div=0 on ch0, then cfg_ch=3 with NUM_CH=3 -> cfg_err pulse each, div unchanged; cfg_valid in RUN -> cfg_ready=0, ignored.
REQ-039 SHALL cover: start and stop together in PAUSED -> IDLE, counters 0; pause and stop together in RUN -> IDLE.
REQ-040 SHALL cover: reset asserted mid-RUN between clock edges -> state=00, tick=0 immediately; all div back to DEFAULT_DIV.
